// File: rtl/pipelined_addsub.sv
// Carry-pipelined adder/subtractor: one CW-bit chunk per stage, carry registered
// between stages, valid/ready handshake with full backpressure.
module pipelined_addsub #(
  parameter int WIDTH  = 12,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int CW = WIDTH / STAGES;

  logic              adv;
  logic [STAGES-1:0] vld_d, vld_q;
  // x*: values entering each stage (stage 0 fed from the ports, stage k from register k-1)
  logic [WIDTH-1:0]  xa [STAGES];
  logic [WIDTH-1:0]  xb [STAGES];
  logic [WIDTH-1:0]  xs [STAGES];
  logic              xc [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              c_d [STAGES];
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic [CW:0]       chunk;
  logic              msb_cin;
  logic [WIDTH-1:0]  sum_d, sum_q;
  logic              cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;

  always_comb begin
    adv      = !vld_q[STAGES-1] || out_ready;
    xa[0]    = a;
    xb[0]    = sub ? ~b : b;
    xc[0]    = sub | cin;
    xs[0]    = '0;
    vld_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      xa[k]    = a_q[k-1];
      xb[k]    = b_q[k-1];
      xc[k]    = c_q[k-1];
      xs[k]    = s_q[k-1];
      vld_d[k] = vld_q[k-1];
    end
    chunk = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk = {1'b0, xa[k][k*CW +: CW]} + {1'b0, xb[k][k*CW +: CW]} + {{CW{1'b0}}, xc[k]};
      a_d[k] = xa[k];
      b_d[k] = xb[k];
      s_d[k] = xs[k];
      s_d[k][k*CW +: CW] = chunk[CW-1:0];
      c_d[k] = chunk[CW];
    end
    sum_d   = s_d[STAGES-1];
    cout_d  = c_d[STAGES-1];
    // carry into the MSB recovered from the MSB sum bit and its two operand bits
    msb_cin = xa[STAGES-1][WIDTH-1] ^ xb[STAGES-1][WIDTH-1] ^ sum_d[WIDTH-1];
    ovf_d   = msb_cin ^ cout_d;
    zero_d  = (sum_d == '0);
  end

  // control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      vld_q  <= vld_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  // inter-stage data registers; bubbles may carry stale data
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, carry-pipelined adder/subtractor; the sequential successor to the fixed 12-bit combinational full adder.
- Splits a WIDTH-bit operation into STAGES equal chunks, one chunk per clock stage, with the carry registered between stages.
- Valid/ready handshake on both sides; full backpressure.
- Sits between operand registers and the datapath result bus in the CA arithmetic units.

Parameters:
- WIDTH, 12, operand/result width in bits; must be divisible by STAGES.
- STAGES, 3, pipeline depth; chunk width CW = WIDTH/STAGES, with CW >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in; used only when sub=0
- sub  input  1  0: A+B+cin, 1: A-B (cin ignored)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB; in subtract mode 1 = no borrow
- ovf  output  1  signed overflow
- zero  output  1  sum == 0

Behaviour:
- Reset: rst_n low asynchronously clears all stage valid bits, sum, cout, ovf and zero to 0. in_ready reads 1 after reset.
- Pipeline advance: adv = !out_valid || out_ready. All stages shift together when adv=1 and hold when adv=0. in_ready = adv (combinational).
- Accept: transfer occurs when in_valid && in_ready.
  - Stage-1 operand B' = sub ? ~b : b.
  - Carry-in c0 = sub ? 1 : cin.
- Stage k (1..STAGES): adds chunk k-1 (bits k*CW-1 : (k-1)*CW) of A and B' plus the registered carry from stage k-1. It then registers:
  - the sum chunk and chunk carry-out,
  - the lower sum chunks already computed,
  - the untouched upper operand chunks.
- Last stage also registers:
  - ovf = carry into MSB XOR carry out of MSB,
  - zero = (full sum == 0),
  - cout = final carry.
- Latency: an operand accepted at edge N appears on out_valid/sum after edge N+STAGES-1, i.e. STAGES register stages with no stall. Throughput: 1 operation per cycle while out_ready=1.
- Bubbles: a stage holding no valid data shifts a 0 valid bit. Data registers in bubbles may hold stale values; outputs are only meaningful when out_valid=1.
- Stall: while out_valid=1 && out_ready=0, sum/cout/ovf/zero/out_valid stay stable and in_ready=0. No operation is lost or duplicated.
- Simultaneous accept and emit in one cycle is legal and required at full rate.
- Results emerge strictly in acceptance order.
- Reset mid-operation: all in-flight operations are discarded. No out_valid occurs after rst_n returns high until new operands are accepted and have travelled STAGES cycles.
- Arithmetic is modulo 2^WIDTH. Signed overflow rules:
  - add: ovf=1 iff a and b share a sign and sum's sign differs;
  - sub: ovf=1 iff a and b differ in sign and sum's sign differs from a's.
- STAGES=1 degenerates to a single registered adder with latency 1.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0, sum=0, cout=0, ovf=0, zero=0; after release in_ready=1.
- Add wrap, WIDTH=12/STAGES=3: a=0xFFF, b=0x001, cin=0, sub=0 → 3 cycles later sum=0x000, cout=1, ovf=0, zero=1. Also a=0x7FF, b=0x001 → sum=0x800, cout=0, ovf=1. Also a=0x0F0, b=0x00F, cin=1 → sum=0x100 (carry crosses chunk boundary).
- Subtract: a=0x005, b=0x007, sub=1 → sum=0xFFE, cout=0, ovf=0. Also a=0x800, b=0x001 → sum=0x7FF, cout=1, ovf=1. Also a=b=0x3A5 → sum=0x000, zero=1, cout=1.
- Backpressure: 20 back-to-back $random operations with random cin/sub, out_ready toggled pseudo-randomly → every result matches a behavioural model in order, none dropped or duplicated, outputs stable while stalled.
- Reset mid-flight: accept 2 operations, pull rst_n low for 1 cycle before either emerges → out_valid drops at once; no stale result appears in the 5 cycles after release.
- Parameter sweep: repeat the random test with (WIDTH, STAGES) = (12,1), (16,4), (32,8) → all results match the model; latency equals STAGES.
